// File: rtl/plot_shadow_fb.sv
// Purpose: 160x120 shadow copy of the pixel plot stream, with a pipelined colour read port and self-clear sweep.
// Latency: plot writes land in the same cycle; reads return rd_valid/rd_colour exactly 2 cycles after acceptance.
// Backpressure: rd_ready=!busy; plots and reads are ignored while a clear sweep runs; reads never stall in RUN.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   x, y, colour, draw_en       plot stream; one write per draw_en cycle when in range
//   clr_req, busy               start a full clear sweep; busy high while sweeping
//   rd_req, rd_x, rd_y          read request, accepted when rd_ready
//   rd_ready, rd_valid          request acceptance; one-cycle data-valid pulse per accepted request
//   rd_colour                   read data, held while rd_valid is low
//   drop_cnt                    saturating count of out-of-range plot writes
module plot_shadow_fb #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int COORD_W  = 9,
    parameter int COLOUR_W = 9,
    parameter int ADDR_W   = 15
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                draw_en,
    input  logic                clr_req,
    output logic                busy,
    input  logic                rd_req,
    input  logic [COORD_W-1:0]  rd_x,
    input  logic [COORD_W-1:0]  rd_y,
    output logic                rd_ready,
    output logic                rd_valid,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic [7:0]          drop_cnt
);

    localparam int                  DEPTH     = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [COORD_W-1:0]  WIDTH_C   = COORD_W'(WIDTH);
    localparam logic [COORD_W-1:0]  HEIGHT_C  = COORD_W'(HEIGHT);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Row-major pixel address; truncation for out-of-range coordinates is
    // harmless because such addresses are never used to touch the RAM.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] px,
                                                   input logic [COORD_W-1:0] py);
        return ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
    endfunction

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_W-1:0]      clr_addr_q;
    logic [ADDR_W-1:0]      clr_addr_d;

    // Shared write port
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [COLOUR_W-1:0]    wr_dat;

    // Plot decode
    logic                   plot_inr;
    logic [ADDR_W-1:0]      plot_addr;
    logic                   drop_inc;

    // Read decode
    logic                   rd_acc;
    logic                   rd_inr;
    logic [ADDR_W-1:0]      rd_addr;
    logic [ADDR_W-1:0]      rd_addr_sel;
    logic                   rd_hit;

    // Read pipeline stage 1 (cycle after acceptance)
    logic                   s1_vld;
    logic                   s1_inr;
    logic                   s1_byp;
    logic [COLOUR_W-1:0]    s1_byp_dat;
    logic [COLOUR_W-1:0]    ram_q;

    logic [COLOUR_W-1:0]    mem [DEPTH];

    assign plot_inr  = (x < WIDTH_C) && (y < HEIGHT_C);
    assign plot_addr = pix_addr(x, y);

    assign rd_inr      = (rd_x < WIDTH_C) && (rd_y < HEIGHT_C);
    assign rd_addr     = pix_addr(rd_x, rd_y);
    // Keep the RAM read address inside the array for out-of-range requests;
    // their data is forced to zero at the output anyway.
    assign rd_addr_sel = rd_inr ? rd_addr : '0;

    assign rd_ready = ~busy;
    assign rd_acc   = rd_req & rd_ready;

    // The RAM returns the pre-write word on a same-cycle collision, so a
    // write landing on the address being read is captured separately.
    assign rd_hit   = wr_en && (wr_addr == rd_addr);

    assign drop_inc = (state_q == ST_RUN) && draw_en && !plot_inr && (drop_cnt != 8'hFF);

    // Next-state and write-port steering
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        busy       = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = plot_addr;
        wr_dat     = colour;

        case (state_q)
            ST_CLEAR: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = clr_addr_q;
                wr_dat  = '0;
                if (clr_req) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                // A plot in the same cycle as clr_req still lands; the sweep
                // that follows wipes it.
                wr_en = draw_en && plot_inr;
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // Frame store: no reset, the clear sweep initialises it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_acc) begin
            ram_q <= mem[rd_addr_sel];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            drop_cnt   <= '0;
            s1_vld     <= 1'b0;
            s1_inr     <= 1'b0;
            s1_byp     <= 1'b0;
            s1_byp_dat <= '0;
            rd_valid   <= 1'b0;
            rd_colour  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;

            if (drop_inc) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_inr     <= rd_inr;
                s1_byp     <= rd_hit;
                s1_byp_dat <= wr_dat;
            end

            // Data is fixed at acceptance time; later writes or a clear
            // starting in between do not alter it.
            rd_valid <= s1_vld;
            if (s1_vld) begin
                if (!s1_inr) begin
                    rd_colour <= '0;
                end else if (s1_byp) begin
                    rd_colour <= s1_byp_dat;
                end else begin
                    rd_colour <= ram_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_plot_shadow_fb.sv
module tb_plot_shadow_fb;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int NPIX  = W * H;

    logic       clk;
    logic       resetn;
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] colour;
    logic       draw_en;
    logic       clr_req;
    logic       busy;
    logic       rd_req;
    logic [8:0] rd_x;
    logic [8:0] rd_y;
    logic       rd_ready;
    logic       rd_valid;
    logic [8:0] rd_colour;
    logic [7:0] drop_cnt;

    plot_shadow_fb dut (
        .clk       (clk),
        .resetn    (resetn),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .draw_en   (draw_en),
        .clr_req   (clr_req),
        .busy      (busy),
        .rd_req    (rd_req),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_colour (rd_colour),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: a plain picture array plus a busy countdown
    int m_pix [NPIX];
    int m_busy;
    int m_left;
    int m_drop;
    int m_last;
    int pend_v, pend_c;
    int cur_v,  cur_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int in_range(input int px, input int py);
        return (px < W) && (py < H);
    endfunction

    task automatic m_wipe();
        for (int i = 0; i < NPIX; i++) m_pix[i] = 0;
    endtask

    task automatic m_reset();
        m_busy = 1; m_left = NPIX; m_drop = 0; m_last = 0;
        pend_v = 0; pend_c = 0; cur_v = 0; cur_c = 0;
        m_wipe();
    endtask

    task automatic idle();
        draw_en = 1'b0; clr_req = 1'b0; rd_req = 1'b0;
    endtask

    // One clock cycle: check this cycle's outputs, advance the model with
    // the inputs currently driven, then move past the edge.
    task automatic tick();
        int new_v, new_c;
        chk("busy",      busy,      m_busy);
        chk("rd_ready",  rd_ready,  !m_busy);
        chk("rd_valid",  rd_valid,  cur_v);
        chk("rd_colour", rd_colour, m_last);
        chk("drop_cnt",  drop_cnt,  m_drop);
        new_v = 0; new_c = 0;
        if (!m_busy) begin
            if (draw_en) begin
                if (in_range(x, y)) m_pix[y*W + x] = colour;
                else if (m_drop < 255) m_drop++;
            end
            if (rd_req) begin
                new_v = 1;
                new_c = in_range(rd_x, rd_y) ? m_pix[rd_y*W + rd_x] : 0;
            end
            if (clr_req) begin
                m_busy = 1; m_left = NPIX; m_wipe();
            end
        end else begin
            if (clr_req) m_left = NPIX;
            else begin
                m_left--;
                if (m_left == 0) m_busy = 0;
            end
        end
        @(posedge clk); #1;
        cur_v = pend_v; cur_c = pend_c;
        pend_v = new_v; pend_c = new_c;
        if (cur_v != 0) m_last = cur_c;
    endtask

    task automatic plot(input int px, input int py, input int c);
        idle();
        draw_en = 1'b1; x = 9'(px); y = 9'(py); colour = 9'(c);
        tick();
        idle();
    endtask

    // Single read with explicit latency checks against a constant
    task automatic rd_check(input string tag, input int px, input int py, input int exp);
        idle();
        rd_req = 1'b1; rd_x = 9'(px); rd_y = 9'(py);
        tick();
        idle();
        chk({tag, "_early"}, rd_valid, 1'b0);
        tick();
        chk({tag, "_vld"}, rd_valid, 1'b1);
        chk(tag, rd_colour, exp);
    endtask

    task automatic rand_xy(output logic [8:0] px, output logic [8:0] py);
        px = 9'($urandom_range(0, 165));
        if ($urandom_range(0, 9) == 0) py = 9'($urandom_range(117, 122));
        else                           py = 9'($urandom_range(0, 3));
    endtask

    task automatic wait_sweep(input string tag, input int exp_len, input int restart_at);
        int n;
        n = 0;
        while (busy && n < NPIX + 1000) begin
            n++;
            clr_req = (n == restart_at);
            tick();
            clr_req = 1'b0;
        end
        chk(tag, n, exp_len);
    endtask

    task automatic hold_reset(input int cycles);
        resetn = 1'b0;
        m_reset();
        #1;
        chk("rst_busy",   busy,      1'b1);
        chk("rst_ready",  rd_ready,  1'b0);
        chk("rst_valid",  rd_valid,  1'b0);
        chk("rst_colour", rd_colour, 9'h0);
        chk("rst_drop",   drop_cnt,  8'h0);
        repeat (cycles) begin
            @(posedge clk); #1;
            chk("rst_hold_valid", rd_valid, 1'b0);
        end
        resetn = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        resetn = 1'b0;
        x = '0; y = '0; colour = '0; rd_x = '0; rd_y = '0;
        idle();

        // Reset and initial sweep
        @(posedge clk); #1;
        hold_reset(3);
        wait_sweep("init_busy_len", NPIX, -1);
        chk("run_ready", rd_ready, 1'b1);
        rd_check("rd_origin", 0, 0, 0);
        rd_check("rd_corner", 159, 119, 0);

        // Plot then read next cycle
        plot(10, 20, 9'h1C0);
        rd_check("rd_plot", 10, 20, 9'h1C0);
        rd_check("rd_below", 10, 21, 0);

        // Same-cycle write-first bypass; T+1 write not visible
        idle();
        draw_en = 1'b1; x = 9'd5; y = 9'd5; colour = 9'h007;
        rd_req = 1'b1; rd_x = 9'd5; rd_y = 9'd5;
        tick();
        idle();
        draw_en = 1'b1; x = 9'd5; y = 9'd5; colour = 9'h038;
        tick();
        idle();
        chk("byp_vld", rd_valid, 1'b1);
        chk("byp_dat", rd_colour, 9'h007);
        tick();
        rd_check("rd_after_byp", 5, 5, 9'h038);

        // Back-to-back reads
        plot(0, 0, 1); plot(1, 0, 2); plot(2, 0, 3);
        rd_req = 1'b1; rd_x = 9'd0; rd_y = 9'd0; tick();
        rd_x = 9'd1; tick();
        chk("b2b_v0", rd_valid, 1'b1); chk("b2b_d0", rd_colour, 9'd1);
        rd_x = 9'd2; tick();
        idle();
        chk("b2b_v1", rd_valid, 1'b1); chk("b2b_d1", rd_colour, 9'd2);
        tick();
        chk("b2b_v2", rd_valid, 1'b1); chk("b2b_d2", rd_colour, 9'd3);
        tick();
        chk("b2b_end", rd_valid, 1'b0);
        chk("b2b_hold", rd_colour, 9'd3);

        // Out-of-range plots
        plot(160, 0, 9'h1FF);
        chk("drop_1", drop_cnt, 8'd1);
        plot(0, 120, 9'h1FF);
        chk("drop_2", drop_cnt, 8'd2);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) plot($urandom_range(160, 511), $urandom_range(0, 511), $urandom_range(0, 511));
            else            plot($urandom_range(0, 159), $urandom_range(120, 511), $urandom_range(0, 511));
        end
        chk("drop_sat", drop_cnt, 8'd255);
        rd_check("rd_after_drop", 10, 20, 9'h1C0);
        rd_check("rd_oor", 200, 3, 0);

        // Randomised traffic in a small window so reads hit recent writes
        for (int i = 0; i < 3000; i++) begin
            idle();
            draw_en = 1'($urandom_range(0, 1));
            rand_xy(x, y);
            colour = 9'($urandom);
            rd_req = 1'($urandom_range(0, 1));
            rand_xy(rd_x, rd_y);
            if ($urandom_range(0, 3) == 0) begin rd_x = x; rd_y = y; end
            tick();
        end
        idle(); tick(); tick();

        // Clear with a plot in the same cycle, reads in flight, restart at 100
        rd_req = 1'b1; rd_x = 9'd10; rd_y = 9'd20; tick();
        idle();
        draw_en = 1'b1; x = 9'd7; y = 9'd7; colour = 9'h1FF; clr_req = 1'b1;
        tick();
        idle();
        chk("clr_inflight_vld", rd_valid, 1'b1);
        chk("clr_inflight_dat", rd_colour, 9'h1C0);
        wait_sweep("clr_busy_len", 100 + NPIX, 100);
        rd_check("clr_pix77", 7, 7, 0);
        rd_check("clr_pix00", 0, 0, 0);
        rd_check("clr_pix1020", 10, 20, 0);
        for (int i = 0; i < 400; i++) begin
            idle();
            rd_req = 1'b1;
            rd_x = 9'($urandom_range(0, 159));
            rd_y = 9'($urandom_range(0, 119));
            tick();
        end
        idle(); tick(); tick();

        // Reset kills a pending read, then reset again mid-sweep
        plot(10, 20, 9'h0AA);
        rd_req = 1'b1; rd_x = 9'd10; rd_y = 9'd20; tick();
        idle();
        hold_reset(3);
        for (int i = 0; i < 5000; i++) tick();
        chk("mid_sweep_busy", busy, 1'b1);
        hold_reset(2);
        wait_sweep("rst_busy_len", NPIX, -1);
        rd_check("rd_after_rst", 10, 20, 0);
        chk("drop_after_rst", drop_cnt, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plot_shadow_fb.md
Name: plot_shadow_fb

Overview:
- Receiving end of the pixel plot stream (x, y, colour, draw_en) produced by GameStateManager, tapped in parallel with the vga_adapter.
- Holds a 160x120 shadow copy of every plotted pixel.
- Provides a pipelined read port so game logic can query on-screen colour, e.g. tile present at the tap row on a KEY press.
- Clears itself after reset and on request.

Parameters:
- WIDTH, 160, pixels per row
- HEIGHT, 120, rows
- COORD_W, 9, width of x/y coordinates
- COLOUR_W, 9, colour width (3 bits per channel)
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- x  in  COORD_W  plot x coordinate
- y  in  COORD_W  plot y coordinate
- colour  in  COLOUR_W  plot colour
- draw_en  in  1  plot strobe; one pixel write per high cycle
- clr_req  in  1  start a full clear sweep
- busy  out  1  high while clearing
- rd_req  in  1  read request
- rd_x  in  COORD_W  read x coordinate
- rd_y  in  COORD_W  read y coordinate
- rd_ready  out  1  read request can be accepted (= !busy)
- rd_valid  out  1  read data valid, one-cycle pulse per accepted request
- rd_colour  out  COLOUR_W  read data
- drop_cnt  out  8  saturating count of out-of-range plot writes

Behaviour:
- Address is y*WIDTH + x, computed at ADDR_W bits.
- A coordinate is in range iff x < WIDTH and y < HEIGHT.
- Reset (async, resetn=0):
  - FSM goes to CLEAR with clear address 0.
  - busy=1, rd_ready=0, rd_valid=0, rd_colour=0, drop_cnt=0.
  - In-flight reads are discarded.
  - RAM contents are not reset; the sweep initialises them.
- CLEAR state:
  - Writes 0 to one address per cycle, from 0 to WIDTH*HEIGHT-1.
  - After the final write (19200 cycles), the next cycle enters RUN with busy=0.
  - draw_en writes are ignored (not counted).
  - rd_req is ignored because rd_ready=0.
  - clr_req asserted during CLEAR restarts the sweep at address 0.
- RUN state:
  - draw_en=1 with an in-range coordinate writes colour at that address in the same cycle.
  - draw_en=1 with an out-of-range coordinate drops the write and increments drop_cnt, saturating at 255. drop_cnt clears only on reset.
  - clr_req=1 enters CLEAR next cycle. If draw_en is also high in that cycle, the write is performed first, then cleared by the sweep.
- Read pipeline (RUN only), fixed latency 2:
  - A request accepted in cycle T (rd_req & rd_ready) gives rd_valid=1 and rd_colour in cycle T+2.
  - One request may be accepted every cycle, fully pipelined with no stalls.
  - rd_colour reflects all writes made in cycles <= T, including a same-cycle write to the same address (write-first bypass). Writes in T+1 are not reflected.
  - An out-of-range read still gives rd_valid at T+2, with rd_colour=0.
  - If clr_req arrives while reads are in flight, those reads still complete with the data captured at acceptance.
  - When rd_valid=0, rd_colour holds its last value.
- RAM: 19200 x COLOUR_W, one write port and one synchronous read port. The clear sweep and plot writes share the write port; the FSM state selects which one drives it.

Test Plan:
- Assert resetn=0 for 3 cycles, then release -> busy=1 for exactly 19200 cycles, then busy=0 and rd_ready=1. Reading (0,0) and (159,119) returns 0.
- Plot (10,20) colour 9'h1C0, then rd_req (10,20) in the next cycle -> rd_valid exactly 2 cycles later with rd_colour=9'h1C0. (10,21) reads 0.
- Same cycle: draw_en (5,5) colour 9'h007 and rd_req (5,5) -> returns 9'h007 at T+2. A write of 9'h038 in T+1 is still returned as 9'h007.
- Back-to-back reads of (0,0), (1,0), (2,0) holding 1, 2, 3 -> rd_valid high for 3 consecutive cycles returning 1, 2, 3 in order.
- Plot at (160,0), (0,120), and 300 further out-of-range writes -> drop_cnt counts 1, 2, then saturates at 255. Shadow contents are unchanged.
- Pulse clr_req in RUN, then pulse it again 100 cycles into the sweep -> busy stays high 100+19200 cycles after the first clr_req, and all pixels read 0. Asserting resetn=0 mid-sweep kills any pending rd_valid and restarts the sweep.
